ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xFF reset.
- Counterpart to the keyboard receive/display path, which decodes device-to-host scan codes.
- Drives the open-drain PS/2 clock and data lines through output-enable signals (oe=1 pulls the line low) and reports the device ACK.
- Sits between the CPU/IO register block and the PS/2 pins; the receiver shares the same pins.

Parameters:
- INHIBIT_CYCLES, 5000, number of clk cycles the host holds ps2_clk low before a request (100 us at 50 MHz).
- TIMEOUT_CYCLES, 1000000, maximum clk cycles allowed between PS/2 clock falling edges before the transfer is aborted (20 ms at 50 MHz).

Ports:
- clk  in  1  system clock.
- clrn  in  1  asynchronous active-low reset.
- tx_data  in  8  command byte.
- tx_valid  in  1  request; accepted only when tx_valid & tx_ready.
- tx_ready  out  1  high in IDLE only.
- ps2_clk_in  in  1  raw PS/2 clock pin level.
- ps2_data_in  in  1  raw PS/2 data pin level.
- ps2_clk_oe  out  1  1 = pull PS/2 clock low.
- ps2_data_oe  out  1  1 = pull PS/2 data low.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse at end of transfer.
- ack_ok  out  1  valid with done: 1 = device ACK seen, 0 = NACK.
- err  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (clrn=0, asynchronous): state IDLE; ps2_clk_oe=0, ps2_data_oe=0, busy=0, done=0, ack_ok=0, err=0, tx_ready=1; counters and shift register cleared.
- Input conditioning:
  - ps2_clk_in and ps2_data_in each pass through a 2-flop synchronizer.
  - A previous-value flop on the synchronized clock gives fall = prev & ~cur.
  - A pin falling edge is therefore seen 3 clk cycles later.
- Accept: in IDLE with tx_valid=1, latch tx_data.
  - Frame = {stop=1, parity, D7..D0}. Parity = ~^tx_data (odd parity).
  - Go to INHIBIT next cycle.
- INHIBIT:
  - ps2_clk_oe=1, ps2_data_oe=0.
  - Counts INHIBIT_CYCLES cycles, then goes to REQ.
- REQ:
  - ps2_data_oe=1 (start bit 0), ps2_clk_oe=0.
  - Bit index = 0. Timeout counter starts.
  - On each fall, ps2_data_oe = ~frame[idx] and idx increments. Falls 1..8 drive D0..D7, fall 9 drives parity, fall 10 drives stop (oe=0).
  - After fall 10, go to ACK.
- ACK: on the next fall (fall 11), sample synchronized data. ack_ok_next = ~data (low = ACK). Go to WAIT_IDLE.
- WAIT_IDLE:
  - Waits until synchronized clock and data are both 1.
  - Then pulses done with ack_ok held and returns to IDLE.
  - ack_ok holds its value until the next accept.
- Timeout:
  - In REQ/ACK/WAIT_IDLE, the counter resets on every fall.
  - If it reaches TIMEOUT_CYCLES: release both oe, pulse err (done not pulsed), go to IDLE.
- The receive path is not gated by this block; the integration ignores received frames while busy=1.
- A tx_valid while busy is ignored (tx_ready=0); there is no queue.
- Reset mid-transfer releases both lines immediately (asynchronous).
- A fall during INHIBIT is ignored. A spurious fall in IDLE has no effect.

Optional Feature:
- Macro PS2_TX_RETRY_EN.
- Defined: on NACK (ack_ok would be 0) or timeout, the block re-enters INHIBIT once with the same latched byte and stays busy. A second failure reports as normal (done with ack_ok=0, or err). A 1-bit retry flag clears on accept.
- Undefined: no retry; the first failure is reported directly.

Test Plan:
- tx_data=0xED; device model clocks 11 falls and pulls data low at fall 11.
  - Data bits sampled on rising edges are 1,0,1,1,0,1,1,1, then parity 1, then stop 1.
  - ps2_clk_oe is high for exactly 5000 cycles first.
  - done pulses with ack_ok=1.
- tx_data=0x07: parity bit is 0. tx_data=0x00: parity bit is 1. Both end with done and ack_ok=1.
- Device leaves data high at fall 11 (NACK), macro undefined: done pulses with ack_ok=0.
  - With PS2_TX_RETRY_EN: a second INHIBIT phase follows, and a successful ACK then gives ack_ok=1.
- Device stops clocking after fall 4: after TIMEOUT_CYCLES, err pulses, both oe=0, tx_ready=1, done stays 0.
- clrn asserted during bit 5: ps2_clk_oe and ps2_data_oe are 0 in the same cycle, busy=0. A new 0xFF request afterwards completes normally.
- tx_valid pulsed while busy: ignored. Exactly one frame is observed on the pins.

Source files
------------

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter driving open-drain clock/data via output enables.
// Define PS2_TX_RETRY_EN to retry once (same byte) after a NACK or timeout.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       err
);

    localparam int unsigned MaxCnt = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                                     INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CntW = $clog2(MaxCnt + 1);
    localparam logic [CntW-1:0] InhibitMax = CntW'(INHIBIT_CYCLES - 1);
    localparam logic [CntW-1:0] TimeoutMax = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StReq,
        StAck,
        StWaitIdle
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      idx_q, idx_d;
    logic [9:0]      frame_q, frame_d;
    logic            data_oe_q, data_oe_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            ack_ok_q, ack_ok_d;
`ifdef PS2_TX_RETRY_EN
    logic            retry_q, retry_d;
`endif

    logic [1:0] clk_sync_q, data_sync_q;
    logic       clk_prev_q;
    logic       clk_s, data_s, fall;
    logic       transfer, timeout;

    // Lines idle high, so the synchronizers reset to 1 to avoid a false fall.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
            data_sync_q <= {data_sync_q[0], ps2_data_in};
            clk_prev_q  <= clk_sync_q[1];
        end
    end

    assign clk_s  = clk_sync_q[1];
    assign data_s = data_sync_q[1];
    assign fall   = clk_prev_q & ~clk_s;

    assign transfer = (state_q == StReq) || (state_q == StAck) || (state_q == StWaitIdle);
    assign timeout  = transfer && !fall && (cnt_q == TimeoutMax);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        frame_d   = frame_q;
        data_oe_d = data_oe_q;
        ack_ok_d  = ack_ok_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
`ifdef PS2_TX_RETRY_EN
        retry_d   = retry_q;
`endif

        if (transfer) begin
            cnt_d = fall ? '0 : cnt_q + CntW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (tx_valid) begin
                    frame_d  = {1'b1, ~^tx_data, tx_data};
                    ack_ok_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = StInhibit;
`ifdef PS2_TX_RETRY_EN
                    retry_d  = 1'b0;
`endif
                end
            end
            StInhibit: begin
                if (cnt_q == InhibitMax) begin
                    cnt_d     = '0;
                    idx_d     = '0;
                    data_oe_d = 1'b1;
                    state_d   = StReq;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StReq: begin
                if (fall) begin
                    data_oe_d = ~frame_q[idx_q];
                    idx_d     = idx_q + 4'd1;
                    if (idx_q == 4'd9) begin
                        state_d = StAck;
                    end
                end
            end
            StAck: begin
                if (fall) begin
                    ack_ok_d = ~data_s;
                    state_d  = StWaitIdle;
                end
            end
            StWaitIdle: begin
                if (clk_s && data_s) begin
`ifdef PS2_TX_RETRY_EN
                    if (!ack_ok_q && !retry_q) begin
                        retry_d = 1'b1;
                        cnt_d   = '0;
                        state_d = StInhibit;
                    end else begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
`else
                    done_d  = 1'b1;
                    state_d = StIdle;
`endif
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort has priority over anything the state decode chose this cycle.
        if (timeout) begin
            data_oe_d = 1'b0;
            done_d    = 1'b0;
            cnt_d     = '0;
`ifdef PS2_TX_RETRY_EN
            if (!retry_q) begin
                retry_d = 1'b1;
                state_d = StInhibit;
            end else begin
                err_d   = 1'b1;
                state_d = StIdle;
            end
`else
            err_d   = 1'b1;
            state_d = StIdle;
`endif
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            idx_q     <= '0;
            frame_q   <= '0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ack_ok_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            frame_q   <= frame_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            err_q     <= err_d;
            ack_ok_q  <= ack_ok_d;
        end
    end

`ifdef PS2_TX_RETRY_EN
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            retry_q <= 1'b0;
        end else begin
            retry_q <= retry_d;
        end
    end
`endif

    assign ps2_clk_oe  = (state_q == StInhibit);
    assign ps2_data_oe = data_oe_q;
    assign busy        = (state_q != StIdle);
    assign tx_ready    = (state_q == StIdle);
    assign done        = done_q;
    assign err         = err_q;
    assign ack_ok      = ack_ok_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: an open-drain device model clocks frames and
// compares sampled bits against a parity/framing model built from the byte value.
module tb_ps2_host_tx;

    localparam int unsigned Inh = 5000;
    localparam int unsigned Tmo = 3000;
    localparam int          H   = 15;

    logic       clk      = 1'b0;
    logic       clrn     = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       dev_clk  = 1'b1;
    logic       dev_data = 1'b1;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, ack_ok, err;
    wire        ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    wire        ps2_data_in = dev_data & ~ps2_data_oe;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(Inh),
        .TIMEOUT_CYCLES(Tmo)
    ) dut (
        .clk        (clk),
        .clrn       (clrn),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .done       (done),
        .ack_ok     (ack_ok),
        .err        (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bits as a device sees them on rising edges: D0..D7, odd parity, stop.
    function automatic logic [9:0] exp_bits(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, ((ones % 2) == 0), b};
    endfunction

    task automatic start_tx(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_before_accept: got %b want 1", tx_ready);
        end
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic device_run(input int nfalls, input bit ack, input int start_limit,
                              output logic [9:0] bits, output int inh_len, output bit req_ok);
        int t = 0;
        bits    = '0;
        inh_len = 0;
        while (!ps2_clk_oe && t < start_limit) begin
            tick();
            t++;
        end
        while (ps2_clk_oe && inh_len < int'(Inh) + 100) begin
            tick();
            inh_len++;
        end
        req_ok = ps2_data_oe && !ps2_clk_oe;
        repeat (10) tick();
        for (int f = 1; f <= nfalls; f++) begin
            if (f == 11) begin
                dev_data = ~ack;
                tick();
            end
            dev_clk = 1'b0;
            repeat (H) tick();
            dev_clk = 1'b1;
            if (f <= 10) bits[f-1] = ps2_data_in;
            if (f == 11) dev_data = 1'b1;
            else repeat (H) tick();
        end
    endtask

    task automatic wait_end(input int limit, output bit got_done, output bit got_err,
                            output logic ack_at_done, output int n);
        got_done    = 1'b0;
        got_err     = 1'b0;
        ack_at_done = 1'bx;
        n           = 0;
        while (!got_done && !got_err && n < limit) begin
            tick();
            n++;
            if (done) begin
                got_done    = 1'b1;
                ack_at_done = ack_ok;
            end
            if (err) got_err = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if ({tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, ack_ok, err} !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 1000000",
                     {tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, ack_ok, err});
        end
        clrn = 1'b1;
        repeat (3) tick();
        checks++;
        if ({tx_ready, busy, ps2_clk_oe, ps2_data_oe} !== 4'b1000) begin
            errors++;
            $display("FAIL idle_after_reset: got %b want 1000",
                     {tx_ready, busy, ps2_clk_oe, ps2_data_oe});
        end
    endtask

    task automatic test_transfer(input logic [7:0] b);
        logic [9:0] bits;
        int         inh, n;
        bit         req, d, e;
        logic       a;
        start_tx(b);
        device_run(11, 1'b1, 200, bits, inh, req);
        checks++;
        if (inh != int'(Inh)) begin
            errors++;
            $display("FAIL inhibit_len %h: got %0d want %0d", b, inh, Inh);
        end
        checks++;
        if (!req) begin
            errors++;
            $display("FAIL request_start_bit %h: got 0 want 1", b);
        end
        checks++;
        if (bits !== exp_bits(b)) begin
            errors++;
            $display("FAIL frame_bits %h: got %b want %b", b, bits, exp_bits(b));
        end
        wait_end(200, d, e, a, n);
        checks++;
        if (!d || e || a !== 1'b1) begin
            errors++;
            $display("FAIL ack_done %h: got done=%b err=%b ack=%b want 1 0 1", b, d, e, a);
        end
        checks++;
        if (tx_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_done %h: got ready=%b busy=%b want 1 0", b, tx_ready, busy);
        end
    endtask

    task automatic test_nack();
        logic [9:0] bits;
        int         inh, n;
        bit         req, d, e;
        logic       a;
        start_tx(8'hF4);
        device_run(11, 1'b0, 200, bits, inh, req);
`ifdef PS2_TX_RETRY_EN
        device_run(11, 1'b1, 200, bits, inh, req);
        checks++;
        if (inh != int'(Inh) || bits !== exp_bits(8'hF4)) begin
            errors++;
            $display("FAIL retry_frame: got inh=%0d bits=%b want %0d %b", inh, bits, Inh,
                     exp_bits(8'hF4));
        end
        wait_end(200, d, e, a, n);
        checks++;
        if (!d || e || a !== 1'b1) begin
            errors++;
            $display("FAIL retry_ack: got done=%b err=%b ack=%b want 1 0 1", d, e, a);
        end
`else
        wait_end(200, d, e, a, n);
        checks++;
        if (!d || e || a !== 1'b0) begin
            errors++;
            $display("FAIL nack_done: got done=%b err=%b ack=%b want 1 0 0", d, e, a);
        end
`endif
    endtask

    task automatic test_timeout();
        logic [9:0] bits;
        int         inh, n;
        bit         req, d, e;
        logic       a;
        // Err follows the last pin fall by 3 sync cycles plus the timeout; the model
        // returns 2*H cycles after that fall.
        int         want = int'(Tmo) + 3 - 2 * H;
        start_tx(8'h5A);
        device_run(4, 1'b1, 200, bits, inh, req);
`ifdef PS2_TX_RETRY_EN
        device_run(4, 1'b1, int'(Tmo) + 200, bits, inh, req);
`endif
        wait_end(int'(Tmo) + 100, d, e, a, n);
        checks++;
        if (!e || d) begin
            errors++;
            $display("FAIL timeout_err: got err=%b done=%b want 1 0", e, d);
        end
        checks++;
        if (n < want - 2 || n > want + 2) begin
            errors++;
            $display("FAIL timeout_delay: got %0d want %0d", n, want);
        end
        checks++;
        if ({ps2_clk_oe, ps2_data_oe, tx_ready} !== 3'b001) begin
            errors++;
            $display("FAIL timeout_release: got %b want 001", {ps2_clk_oe, ps2_data_oe, tx_ready});
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] bits;
        int         inh;
        bit         req;
        start_tx(8'h2C);
        device_run(5, 1'b1, 200, bits, inh, req);
        checks++;
        if (ps2_data_oe !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_bit5_state: got oe=%b busy=%b want 1 1", ps2_data_oe, busy);
        end
        clrn = 1'b0;
        #1;
        checks++;
        if ({ps2_clk_oe, ps2_data_oe, busy} !== 3'b000) begin
            errors++;
            $display("FAIL async_reset_release: got %b want 000", {ps2_clk_oe, ps2_data_oe, busy});
        end
        tick();
        clrn = 1'b1;
        tick();
        test_transfer(8'hFF);
    endtask

    task automatic test_idle_fall();
        bit bad = 1'b0;
        dev_clk = 1'b0;
        repeat (H) begin
            tick();
            if (busy || ps2_clk_oe || ps2_data_oe || done || err) bad = 1'b1;
        end
        dev_clk = 1'b1;
        repeat (H) begin
            tick();
            if (busy || ps2_clk_oe || ps2_data_oe || done || err) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL idle_spurious_fall: got activity=1 want 0");
        end
    endtask

    task automatic test_busy_ignored();
        logic [9:0] bits;
        int         inh, n;
        bit         req, d, e, extra;
        logic       a;
        start_tx(8'hED);
        repeat (50) tick();
        tx_data  = 8'h12;
        tx_valid = 1'b1;
        checks++;
        if (tx_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_flags: got ready=%b busy=%b want 0 1", tx_ready, busy);
        end
        tick();
        tx_valid = 1'b0;
        device_run(11, 1'b1, 200, bits, inh, req);
        checks++;
        if (bits !== exp_bits(8'hED)) begin
            errors++;
            $display("FAIL busy_frame: got %b want %b", bits, exp_bits(8'hED));
        end
        wait_end(200, d, e, a, n);
        checks++;
        if (!d || a !== 1'b1) begin
            errors++;
            $display("FAIL busy_done: got done=%b ack=%b want 1 1", d, a);
        end
        extra = 1'b0;
        repeat (Inh + 200) begin
            tick();
            if (ps2_clk_oe || busy) extra = 1'b1;
        end
        checks++;
        if (extra) begin
            errors++;
            $display("FAIL single_frame: got second request=1 want 0");
        end
    endtask

    initial begin
        test_reset();
        test_idle_fall();
        test_transfer(8'hED);
        test_transfer(8'h07);
        test_transfer(8'h00);
        for (int i = 0; i < 3; i++) test_transfer(8'($urandom_range(0, 255)));
        test_nack();
        test_timeout();
        test_reset_mid();
        test_busy_ignored();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
